// File: rtl/uart_rx_frame.sv
// UART receiver: sysclk-divided oversampling, 3-sample majority vote, optional parity,
// 1/2 stop bits, held receive register with acknowledge and error reporting.
module uart_rx_frame #(
    parameter int unsigned data_bits   = 8,
    parameter int unsigned parity_mode = 0,
    parameter int unsigned stop_bits   = 1,
    parameter int unsigned os_rate     = 16,
    parameter int unsigned tick_div    = 13
) (
    input  logic                 sysclk,
    input  logic                 rstH,
    input  logic                 rxd,
    output logic [data_bits-1:0] RDR,
    output logic                 rxd_readyH,
    input  logic                 rxd_ackH,
    output logic                 parity_errH,
    output logic                 frame_errH,
    output logic                 break_errH,
    output logic                 overrun_errH
);

    localparam int unsigned TickW = $clog2(tick_div);
    localparam int unsigned CellW = $clog2(os_rate);
    localparam logic [TickW-1:0] TickLast = TickW'(tick_div - 1);
    localparam logic [CellW-1:0] CellLast = CellW'(os_rate - 1);
    localparam logic [CellW-1:0] SmpA     = CellW'(os_rate / 2 - 1);
    localparam logic [CellW-1:0] SmpB     = CellW'(os_rate / 2);
    localparam logic [CellW-1:0] SmpC     = CellW'(os_rate / 2 + 1);
    localparam logic [3:0]       DataLast = 4'(data_bits - 1);
    localparam logic [3:0]       StopLast = 4'(stop_bits - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [CellW-1:0]     cell_q, cell_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [data_bits-1:0] shift_q, shift_d;
    logic                 smp_a_q, smp_a_d, smp_b_q, smp_b_d;
    logic                 zero_q, zero_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 armed_q, armed_d;
    logic [data_bits-1:0] rdr_q, rdr_d;
    logic                 ready_q, ready_d, pe_q, pe_d, fe_q, fe_d, be_q, be_d, ov_q, ov_d;

    logic tick, maj, decide, cell_end, commit, commit_fe, commit_be;

    always_ff @(posedge sysclk or posedge rstH) begin
        if (rstH) begin
            state_q    <= StIdle;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            tick_cnt_q <= '0;
            cell_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            smp_a_q    <= 1'b0;
            smp_b_q    <= 1'b0;
            zero_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            armed_q    <= 1'b1;
            rdr_q      <= '0;
            ready_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            be_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            cell_q     <= cell_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            smp_a_q    <= smp_a_d;
            smp_b_q    <= smp_b_d;
            zero_q     <= zero_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            armed_q    <= armed_d;
            rdr_q      <= rdr_d;
            ready_q    <= ready_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            be_q       <= be_d;
            ov_q       <= ov_d;
        end
    end

    always_comb begin
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
        maj        = (smp_a_q & smp_b_q) | (smp_a_q & sync2_q) | (smp_b_q & sync2_q);
        decide     = (cell_q == SmpC);
        cell_end   = (cell_q == CellLast);
        state_d    = state_q;
        cell_d     = cell_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        smp_a_d    = smp_a_q;
        smp_b_d    = smp_b_q;
        zero_d     = zero_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        armed_d    = armed_q;
        rdr_d      = rdr_q;
        ready_d    = ready_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        be_d       = be_q;
        ov_d       = ov_q;
        commit     = 1'b0;
        commit_fe  = 1'b0;
        commit_be  = 1'b0;

        if (tick) begin
            if (cell_q == SmpA) smp_a_d = sync2_q;
            if (cell_q == SmpB) smp_b_d = sync2_q;
            cell_d = cell_end ? '0 : cell_q + CellW'(1);
            unique case (state_q)
                StIdle: begin
                    cell_d = '0;
                    if (sync2_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d   = StStart;
                        cell_d    = CellW'(1);
                        bit_cnt_d = '0;
                        zero_d    = 1'b1;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
                StStart: begin
                    if (decide && maj) begin
                        state_d = StIdle;
                        cell_d  = '0;
                    end else if (cell_end) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (decide) begin
                        shift_d = {maj, shift_q[data_bits-1:1]};
                        zero_d  = zero_q & ~maj;
                    end
                    if (cell_end) begin
                        if (bit_cnt_q == DataLast) begin
                            bit_cnt_d = '0;
                            state_d   = (parity_mode != 0) ? StParity : StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (decide) begin
                        perr_d = ((^shift_q) ^ maj) != (parity_mode == 2);
                        zero_d = zero_q & ~maj;
                    end
                    if (cell_end) state_d = StStop;
                end
                StStop: begin
                    // The last stop bit commits at its decision point, not at the cell end.
                    if (decide && bit_cnt_q == StopLast) begin
                        commit    = 1'b1;
                        commit_fe = ferr_q | ~maj;
                        commit_be = commit_fe & zero_q & ~maj;
                        state_d   = StIdle;
                        cell_d    = '0;
                        if (commit_fe) armed_d = 1'b0;
                    end else if (decide) begin
                        ferr_d = ferr_q | ~maj;
                        zero_d = zero_q & ~maj;
                    end
                    if (cell_end) bit_cnt_d = bit_cnt_q + 4'd1;
                end
                default: state_d = StIdle;
            endcase
        end

        if (commit) begin
            if (!ready_q || rxd_ackH) begin
                rdr_d   = shift_q;
                pe_d    = perr_q;
                fe_d    = commit_fe;
                be_d    = commit_be;
                ready_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (rxd_ackH && ready_q) begin
            ready_d = 1'b0;
            ov_d    = 1'b0;
        end
    end

    assign RDR          = rdr_q;
    assign rxd_readyH   = ready_q;
    assign parity_errH  = pe_q;
    assign frame_errH   = fe_q;
    assign break_errH   = be_q;
    assign overrun_errH = ov_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 and an 8E2 receiver checked every cycle against a
// frame-level model (expected commits scheduled by tick arithmetic) plus literal spot checks.
module tb_uart_rx_frame;

    localparam int TD  = 4;
    localparam int OS  = 16;
    localparam int CPB = TD * OS;

    typedef struct {
        int         inst;
        int         edge_no;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       be;
    } commit_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rxd = 2'b11;
    logic [1:0] ack = 2'b00;
    logic [7:0] rdr [2];
    logic [1:0] rdy, pe, fe, be, ov;

    int      cyc;
    int      n_checks = 0;
    int      n_errs = 0;
    int      ack_edge [2];
    int      pend_edge [2];
    commit_t cq [$];

    logic [7:0] e_rdr [2];
    logic [1:0] e_rdy, e_pe, e_fe, e_be, e_ov;
    int         hit;
    bit         a_hit;

    uart_rx_frame #(
        .data_bits(8), .parity_mode(0), .stop_bits(1), .os_rate(OS), .tick_div(TD)
    ) u_dut0 (
        .sysclk(clk), .rstH(rst), .rxd(rxd[0]), .RDR(rdr[0]), .rxd_readyH(rdy[0]),
        .rxd_ackH(ack[0]), .parity_errH(pe[0]), .frame_errH(fe[0]), .break_errH(be[0]),
        .overrun_errH(ov[0])
    );

    uart_rx_frame #(
        .data_bits(8), .parity_mode(1), .stop_bits(2), .os_rate(OS), .tick_div(TD)
    ) u_dut1 (
        .sysclk(clk), .rstH(rst), .rxd(rxd[1]), .RDR(rdr[1]), .rxd_readyH(rdy[1]),
        .rxd_ackH(ack[1]), .parity_errH(pe[1]), .frame_errH(fe[1]), .break_errH(be[1]),
        .overrun_errH(ov[1])
    );

    always #5 clk = ~clk;

    // Edge index since reset release; ticks fall on edges with index % TD == TD-1.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int pm(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int sb(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Line first driven low before edge n0; two sync flops, then the next tick detects it.
    function automatic int commit_edge(input int n0, input int ncells);
        int det;
        det = n0 + 2;
        while (det % TD != TD - 1) det++;
        return det + TD * (OS * (ncells - 1) + OS / 2 + 1);
    endfunction

    function automatic logic [31:0] dut_pack(input int i);
        return {19'b0, rdr[i], rdy[i], pe[i], fe[i], be[i], ov[i]};
    endfunction

    function automatic logic [31:0] exp_pack(input int i);
        return {19'b0, e_rdr[i], e_rdy[i], e_pe[i], e_fe[i], e_be[i], e_ov[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) e_rdr[i] = '0;
            e_rdy = '0; e_pe = '0; e_fe = '0; e_be = '0; e_ov = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                hit = -1;
                foreach (cq[k]) if (cq[k].inst == i && cq[k].edge_no == cyc - 1) hit = k;
                a_hit = (ack_edge[i] == cyc - 1);
                if (hit >= 0) begin
                    if (!e_rdy[i] || a_hit) begin
                        e_rdr[i] = cq[hit].d;
                        e_pe[i]  = cq[hit].pe;
                        e_fe[i]  = cq[hit].fe;
                        e_be[i]  = cq[hit].be;
                        e_rdy[i] = 1'b1;
                    end else begin
                        e_ov[i] = 1'b1;
                    end
                    cq.delete(hit);
                end else if (a_hit && e_rdy[i]) begin
                    e_rdy[i] = 1'b0;
                    e_ov[i]  = 1'b0;
                end
                check($sformatf("outputs u_dut%0d {rdr,rdy,pe,fe,be,ov}", i),
                      dut_pack(i), exp_pack(i));
            end
        end
    end

    task automatic hold(input int i, input logic v, input int n);
        rxd[i] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rxd = 2'b11;
        ack = 2'b00;
        cq.delete();
        ack_edge  = '{-1, -1};
        pend_edge = '{-1, -1};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) check($sformatf("reset outputs u_dut%0d", i), dut_pack(i), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic ack_pulse(input int i);
        @(negedge clk);
        ack[i]      = 1'b1;
        ack_edge[i] = cyc;
        @(negedge clk);
        ack[i] = 1'b0;
    endtask

    task automatic ack_at_commit(input int i);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (pend_edge[i] == cyc) begin
                ack[i]      = 1'b1;
                ack_edge[i] = cyc;
                @(negedge clk);
                ack[i] = 1'b0;
                done   = 1'b1;
            end
        end
        check("ack-at-commit reached within bound", 32'(done), 32'd1);
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input bit flip,
                              input logic [1:0] st);
        commit_t cm;
        logic    p;
        int      np, ns;
        np = (pm(i) != 0) ? 1 : 0;
        ns = sb(i);
        p  = (^d) ^ (pm(i) == 2) ^ flip;
        @(negedge clk);
        cm.inst    = i;
        cm.edge_no = commit_edge(cyc, 1 + 8 + np + ns);
        cm.d       = d;
        cm.pe      = (np != 0) && (((^d) ^ p) != (pm(i) == 2));
        cm.fe      = (ns == 1) ? !st[0] : !(st[0] && st[1]);
        cm.be      = cm.fe && (d == 8'h00) && (np == 0 || !p) &&
                     ((ns == 1) ? !st[0] : (st == 2'b00));
        cq.push_back(cm);
        pend_edge[i] = cm.edge_no;
        hold(i, 1'b0, CPB);
        for (int b = 0; b < 8; b++) hold(i, d[b], CPB);
        if (np != 0) hold(i, p, CPB);
        for (int s = 0; s < ns; s++) hold(i, st[s], CPB);
        rxd[i] = 1'b1;
    endtask

    task automatic hold_break(input int i, input int n);
        commit_t cm;
        int      np;
        np = (pm(i) != 0) ? 1 : 0;
        @(negedge clk);
        cm.inst    = i;
        cm.edge_no = commit_edge(cyc, 1 + 8 + np + sb(i));
        cm.d       = 8'h00;
        cm.pe      = (np != 0) && (pm(i) == 2);
        cm.fe      = 1'b1;
        cm.be      = 1'b1;
        cq.push_back(cm);
        hold(i, 1'b0, n);
        rxd[i] = 1'b1;
    endtask

    initial begin
        apply_reset();

        // Abandon a frame part-way with a reset; nothing may commit afterwards.
        @(negedge clk);
        hold(0, 1'b0, CPB);
        hold(0, 1'b1, 2 * CPB);
        hold(0, 1'b0, 100);
        apply_reset();
        idle(800);
        check("no commit after mid-frame reset", 32'(rdy[0]), 32'd0);

        send_frame(0, 8'hA5, 1'b0, 2'b11);
        idle(4);
        check("8N1 0xA5 RDR", 32'(rdr[0]), 32'hA5);
        check("8N1 0xA5 ready", 32'(rdy[0]), 32'd1);
        check("8N1 0xA5 flags", 32'({pe[0], fe[0], be[0], ov[0]}), 32'd0);
        ack_pulse(0);
        idle(2);
        check("ack clears ready", 32'(rdy[0]), 32'd0);
        check("RDR holds after ack", 32'(rdr[0]), 32'hA5);

        send_frame(1, 8'h5A, 1'b1, 2'b11);
        idle(4);
        check("8E2 0x5A RDR", 32'(rdr[1]), 32'h5A);
        check("8E2 wrong parity flagged", 32'(pe[1]), 32'd1);
        ack_pulse(1);
        idle(8);
        send_frame(1, 8'h5A, 1'b0, 2'b11);
        idle(4);
        check("8E2 good parity", 32'(pe[1]), 32'd0);
        ack_pulse(1);

        idle(16);
        send_frame(0, 8'h81, 1'b0, 2'b00);
        idle(4);
        check("low stop -> frame_err", 32'({fe[0], be[0]}), 32'b10);
        ack_pulse(0);
        idle(16);

        hold_break(0, 3 * 10 * CPB);
        idle(16);
        check("break RDR", 32'(rdr[0]), 32'h00);
        check("break flags {rdy,fe,be,ov}", 32'({rdy[0], fe[0], be[0], ov[0]}), 32'b1110);
        ack_pulse(0);
        idle(16);
        send_frame(0, 8'h3C, 1'b0, 2'b11);
        idle(4);
        check("0x3C after break", 32'({rdr[0], fe[0], be[0]}), 32'({8'h3C, 2'b00}));
        ack_pulse(0);
        idle(16);

        // Three low ticks is a false start; a frame soon after must still be caught.
        @(negedge clk);
        hold(0, 1'b0, 3 * TD);
        hold(0, 1'b1, 40);
        check("glitch gives no commit", 32'(rdy[0]), 32'd0);
        send_frame(0, 8'h77, 1'b0, 2'b11);
        idle(4);
        check("frame after glitch", 32'(rdr[0]), 32'h77);
        ack_pulse(0);
        idle(16);

        send_frame(0, 8'h11, 1'b0, 2'b11);
        idle(20);
        send_frame(0, 8'h22, 1'b0, 2'b11);
        idle(4);
        check("overrun keeps first RDR", 32'(rdr[0]), 32'h11);
        check("overrun flag", 32'(ov[0]), 32'd1);
        ack_pulse(0);
        idle(2);
        check("ack clears overrun", 32'({rdy[0], ov[0]}), 32'd0);
        send_frame(0, 8'h11, 1'b0, 2'b11);
        idle(20);
        pend_edge[0] = -1;
        fork
            send_frame(0, 8'h22, 1'b0, 2'b11);
            ack_at_commit(0);
        join
        idle(4);
        check("ack on commit loads 0x22", 32'({rdr[0], rdy[0], ov[0]}), 32'({8'h22, 2'b10}));
        ack_pulse(0);
        idle(16);

        for (int i = 0; i < 2; i++) begin
            for (int f = 0; f < 20; f++) begin
                logic [7:0] d;
                bit         flip;
                logic [1:0] st;
                int         dly;
                d    = 8'($urandom);
                flip = ($urandom_range(0, 3) == 0);
                st   = 2'b11;
                if ($urandom_range(0, 5) == 0) st = 2'($urandom_range(0, 2));
                dly = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 900));
                fork
                    send_frame(i, d, flip, st);
                    begin
                        if (dly != 0) begin
                            repeat (dly) @(negedge clk);
                            ack_pulse(i);
                        end
                    end
                join
                idle(int'($urandom_range(8, 90)));
            end
        end

        idle(200);
        check("all scheduled commits reached", 32'(cq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver that replaces the fixed 8-bit, baud-code-selected receiver in the UART pair. It adds configurable data width, optional even/odd parity, 1 or 2 stop bits, a sysclk-divided oversampling clock, and 3-sample majority voting. It also adds a held receive register with acknowledge, and parity, framing, break and overrun reporting. It sits between the `rxd` line (after the line driver) and the host bus that reads `RDR`.

## Interface
- `data_bits`, 8: data bits per frame, legal 5..9.
- `parity_mode`, 0: 0 = none, 1 = even, 2 = odd.
- `stop_bits`, 1: stop bits checked, 1 or 2.
- `os_rate`, 16: oversample ticks per bit cell, even, ≥8.
- `tick_div`, 13: `sysclk` cycles per oversample tick, ≥2.
- `sysclk`  in  1  system clock, rising edge.
- `rstH`  in  1  reset, asynchronous assert, active-high.
- `rxd`  in  1  serial input, asynchronous to `sysclk`, idle high.
- `RDR`  out  data_bits  received data, LSB = first data bit received.
- `rxd_readyH`  out  1  `RDR` holds an unread frame (level).
- `rxd_ackH`  in  1  host read strobe; one-cycle pulse clears `rxd_readyH`.
- `parity_errH`  out  1  parity mismatch on the frame in `RDR`.
- `frame_errH`  out  1  a stop bit was sampled low on the frame in `RDR`.
- `break_errH`  out  1  frame in `RDR` was all-zero, including parity and stop bits.
- `overrun_errH`  out  1  sticky; a completed frame was discarded.

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1.
- The tick counter is free-running, 0..`tick_div`-1, and emits a one-cycle tick at `tick_div`-1.
- All state changes below happen on tick cycles only.
- Cell tick counter `c` runs 0..`os_rate`-1 in each bit cell.
- Samples are taken at `c` = `os_rate`/2-1, `os_rate`/2 and `os_rate`/2+1.
- The bit value is the majority of those three samples, decided at `c` = `os_rate`/2+1.
- States:
  - IDLE: waits for a synchronised 0 while `armed`=1 → START, `c`=1.
  - START: if the bit decides 1, this is a false start → IDLE. Otherwise at `c`=`os_rate`-1 → DATA.
  - DATA: shifts the decided bit in, LSB first. After `data_bits` cells → PARITY if `parity_mode`≠0, else STOP.
  - PARITY: one cell. Error when (XOR of data bits) ^ parity bit ≠ (`parity_mode`==2).
  - STOP: `stop_bits` cells. Any stop bit deciding 0 is a framing error. At the decision point of the last stop bit the frame commits and the state returns to IDLE, without waiting for the cell end.
- Commit:
  - If `rxd_readyH`=0, or `rxd_ackH`=1 in the same cycle: load `RDR` and the three frame flags, and set `rxd_readyH`=1.
  - Otherwise: `RDR` and the flags are unchanged, and `overrun_errH` is set to 1.
- `break_errH` = framing error AND every decided bit from data through stop is 0. `frame_errH` is also 1 in this case.
- `armed` clears on a framing-error commit and sets on the first synchronised 1 seen in IDLE. This prevents a held-low line from producing back-to-back frames.
- `rxd_ackH` with no commit in the same cycle clears `rxd_readyH` and `overrun_errH` on the next edge. `RDR` and the frame flags hold their values.
- `rxd_ackH` while `rxd_readyH`=0 has no effect.

## Timing
- Reset values:
  - all outputs 0, `RDR`=0;
  - state IDLE, `armed`=1;
  - tick counter 0, `c`=0.
- Reset mid-frame abandons the frame with no commit.
- Start detection lags the `rxd` edge by 2 cycles for synchronisation, plus at most `tick_div` cycles to the next tick.
- Commit tick, counted from the start-detection tick: (`os_rate`·(1+`data_bits`+P+`stop_bits`-1) + `os_rate`/2+1) ticks, where P = 1 if parity is enabled, else 0.
- Outputs are registered. They are visible 1 cycle after the commit tick edge.
- Minimum gap between frame ends that the receiver accepts: `os_rate`/2-1 ticks, which absorbs ±4% baud error at `os_rate`=16.

## Test plan
All scenarios use `tick_div`=4 and `os_rate`=16, giving 64 cycles per bit.
- Reset: assert `rstH` mid-frame, then release with `rxd`=1 → all outputs 0 and no commit.
- 8N1, send 0xA5 → `RDR`=0xA5, `rxd_readyH`=1, all error flags 0. `rxd_ackH` pulse → `rxd_readyH`=0, `RDR` stays 0xA5.
- `parity_mode`=1, send 0x5A with parity bit 1 (wrong) → `RDR`=0x5A, `parity_errH`=1. Repeat with parity bit 0 → `parity_errH`=0.
- Stop bit driven low → `frame_errH`=1.
- Hold `rxd` low for 3 frame times → exactly one commit with `RDR`=0x00 and `break_errH`=1. After `rxd` returns high, a subsequent 0x3C is received cleanly.
- Low glitch lasting 3 ticks → no commit; state is IDLE by `c`=9.
- Send 0x11 then 0x22 with no ack → `RDR`=0x11, `overrun_errH`=1.
- Repeat, with `rxd_ackH` asserted in the second frame's commit cycle → `RDR`=0x22, `overrun_errH`=0.
